// File: rtl/tdcchan_readout_if.sv
// Interface bundle for the TDC channel readout controller: the channel-side
// request/serial lines, the valid/ready output stream and the status outputs.
`timescale 1ns/1ps
interface tdcchan_readout_if #(
  parameter int DATA_W = 12,
  parameter int BC_W   = 7
);
  logic              tdc_rdy;
  logic              rstr;
  logic              rdata;
  logic              out_valid;
  logic              out_ready;
  logic [BC_W-1:0]   out_bc;
  logic [DATA_W-1:0] out_tdc;
  logic              overflow;
  logic [7:0]        err_count;

  // Readout controller side
  modport master (
    input  tdc_rdy, rdata, out_ready,
    output rstr, out_valid, out_bc, out_tdc, overflow, err_count
  );

  // Channel / event-builder side
  modport slave (
    output tdc_rdy, rdata, out_ready,
    input  rstr, out_valid, out_bc, out_tdc, overflow, err_count
  );
endinterface

// File: rtl/tdcchan_readout.sv
// Host-side readout controller for a TDC channel: requests a measurement,
// deserializes the framed serial word, checks even parity and buffers good
// words in a first-word-fall-through FIFO toward the event builder.
`timescale 1ns/1ps
module tdcchan_readout #(
  parameter int DATA_W     = 12,
  parameter int BC_W       = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_MAX   = 8
) (
  input  logic               clk300,
  input  logic               reset,
  tdcchan_readout_if.master  bus
);
  localparam int WORD_W = BC_W + DATA_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WC_W   = $clog2(WAIT_MAX + 1);
  localparam int BCNT_W = $clog2(WORD_W);

  localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(WAIT_MAX - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_PUSH   = 3'd5;

  // Data bits plus parity bit must carry an even number of ones.
  function automatic logic parity_ok(input logic [WORD_W-1:0] word, input logic par);
    return ~((^word) ^ par);
  endfunction

  logic [2:0]        state_r;
  logic              rstr_r;
  logic [WC_W-1:0]   wait_cnt_r;
  logic [BCNT_W-1:0] bit_cnt_r;
  logic [WORD_W-1:0] shift_r;
  logic              overflow_r;
  logic [7:0]        err_count_r;

  logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              out_valid_r;
  logic [WORD_W-1:0] head_r;

  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              err_inc_s;
  logic [PTR_W-1:0]  rd_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [WORD_W-1:0] head_nxt_s;

  assign full_s   = (cnt_r == CNT_FULL);
  assign push_s   = (state_r == ST_PUSH);
  assign pop_s    = out_valid_r & bus.out_ready;
  assign rd_nxt_s = rd_ptr_r + PTR_W'(1);

  // Dropped-frame condition: start-bit timeout or parity failure.
  always_comb begin
    err_inc_s = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (!bus.rdata && (wait_cnt_r == WAIT_LAST)) err_inc_s = 1'b1;
        else                                         err_inc_s = 1'b0;
      end
      ST_PARITY: begin
        if (!parity_ok(shift_r, bus.rdata)) err_inc_s = 1'b1;
        else                                err_inc_s = 1'b0;
      end
      default: err_inc_s = 1'b0;
    endcase
  end

  // Readout sequencer: request, wait for start bit, shift word, check parity.
  always_ff @(posedge clk300) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      rstr_r     <= 1'b0;
      wait_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
    end else begin
      rstr_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.tdc_rdy && !full_s) begin
            state_r <= ST_REQ;
            rstr_r  <= 1'b1;
          end
        end
        ST_REQ: begin
          state_r    <= ST_WAIT;
          wait_cnt_r <= '0;
        end
        ST_WAIT: begin
          if (bus.rdata) begin
            state_r   <= ST_SHIFT;
            bit_cnt_r <= '0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
          end
        end
        ST_SHIFT: begin
          shift_r <= {shift_r[WORD_W-2:0], bus.rdata};
          if (bit_cnt_r == BIT_LAST) state_r <= ST_PARITY;
          else                       bit_cnt_r <= bit_cnt_r + BCNT_W'(1);
        end
        ST_PARITY: begin
          if (parity_ok(shift_r, bus.rdata)) state_r <= ST_PUSH;
          else                               state_r <= ST_IDLE;
        end
        ST_PUSH: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flag and saturating dropped-frame counter.
  always_ff @(posedge clk300) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      if ((state_r == ST_IDLE) && bus.tdc_rdy && full_s) overflow_r <= 1'b1;
      if (err_inc_s && (err_count_r != 8'hFF)) err_count_r <= err_count_r + 8'd1;
    end
  end

  // Next occupancy and next head word; the head is held in a register so the
  // stream outputs come straight from flops.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    head_nxt_s = head_r;
    if (push_s && !pop_s)      cnt_nxt_s = cnt_r + CNT_W'(1);
    else if (!push_s && pop_s) cnt_nxt_s = cnt_r - CNT_W'(1);
    else                       cnt_nxt_s = cnt_r;

    if (cnt_nxt_s == '0)                  head_nxt_s = '0;
    else if (cnt_r == '0)                 head_nxt_s = shift_r;
    else if (pop_s && (cnt_r == CNT_W'(1))) head_nxt_s = shift_r;
    else if (pop_s)                       head_nxt_s = mem_r[rd_nxt_s];
    else                                  head_nxt_s = head_r;
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk300) begin
    if (push_s) mem_r[wr_ptr_r] <= shift_r;
  end

  // FIFO pointers, occupancy and registered head/valid.
  always_ff @(posedge clk300) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      head_r      <= '0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= (cnt_nxt_s != '0);
      head_r      <= head_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_nxt_s;
    end
  end

  assign bus.rstr      = rstr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_bc    = head_r[WORD_W-1:DATA_W];
  assign bus.out_tdc   = head_r[DATA_W-1:0];
  assign bus.overflow  = overflow_r;
  assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_tdcchan_readout.sv
// Bench for tdcchan_readout: directed frame table, multi-cycle corner
// sequences and a randomized run against a transaction-level model
// (expected-word queue plus dropped-frame count).
`timescale 1ns/1ps
module tb_tdcchan_readout;
  localparam int DATA_W   = 12;
  localparam int BC_W     = 7;
  localparam int WAIT_MAX = 8;
  localparam int WORD_W   = BC_W + DATA_W;

  logic clk300 = 1'b0;
  logic reset;
  always #5 clk300 = ~clk300;

  tdcchan_readout_if #(.DATA_W(DATA_W), .BC_W(BC_W)) bus ();
  tdcchan_readout #(.DATA_W(DATA_W), .BC_W(BC_W), .FIFO_DEPTH(4), .WAIT_MAX(WAIT_MAX))
    dut (.clk300(clk300), .reset(reset), .bus(bus));

  int n_checks  = 0;
  int n_fail    = 0;
  int rstr_cnt  = 0;
  int err_model = 0;
  bit rand_ready = 1'b0;
  logic [WORD_W-1:0] exp_q[$];

  typedef struct {
    int          dly;        // start-bit latency after rstr, 0 = never
    logic [6:0]  bc;
    logic [11:0] tdc;
    bit          good;       // parity bit correct
    bit          exp_valid;
    logic [7:0]  exp_err;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; inputs change and outputs are read 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk300);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rstr();
    int n;
    n = 0;
    while (bus.rstr !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("rstr_wait", bus.rstr, 1'b1);
  endtask

  // Called in the rstr cycle R; returns in cycle S+21 (or R+WAIT_MAX on timeout).
  task automatic send_frame(input int dly, input logic [6:0] bc, input logic [11:0] tdc, input bit good);
    logic [WORD_W-1:0] w;
    logic par;
    w   = {bc, tdc};
    par = (($countones(w) % 2) != 0);
    if (!good) par = ~par;
    if (dly < 1 || dly > WAIT_MAX) begin
      repeat (WAIT_MAX) tick();
      if (err_model < 255) err_model++;
    end else begin
      repeat (dly) tick();
      bus.rdata = 1'b1;
      for (int k = 0; k < WORD_W; k++) begin
        tick();
        bus.rdata = w[WORD_W-1-k];
      end
      tick();
      bus.rdata = par;
      tick();
      bus.rdata = 1'b0;
      if (good) exp_q.push_back(w);
      else if (err_model < 255) err_model++;
    end
  endtask

  task automatic read_one(input int dly, input logic [6:0] bc, input logic [11:0] tdc, input bit good);
    bus.tdc_rdy = 1'b1;
    wait_rstr();
    bus.tdc_rdy = 1'b0;
    send_frame(dly, bc, tdc, good);
  endtask

  // Stream monitor: every accepted head word must match the model queue.
  always @(negedge clk300) begin
    if (bus.rstr === 1'b1) rstr_cnt++;
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no word", {bus.out_bc, bus.out_tdc});
      end else begin
        check("pop_word", {bus.out_bc, bus.out_tdc}, exp_q.pop_front());
      end
    end
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    logic [WORD_W-1:0] w;
    int dly;
    bit good;

    vecs[0] = '{2, 7'h55, 12'hABC, 1'b1, 1'b1, 8'd0};
    vecs[1] = '{2, 7'h55, 12'hABC, 1'b0, 1'b0, 8'd1};
    vecs[2] = '{1, 7'h00, 12'h000, 1'b1, 1'b1, 8'd1};
    vecs[3] = '{8, 7'h7F, 12'hFFF, 1'b1, 1'b1, 8'd1};
    vecs[4] = '{0, 7'h00, 12'h000, 1'b1, 1'b0, 8'd2};
    vecs[5] = '{5, 7'h01, 12'h800, 1'b1, 1'b1, 8'd2};
    vecs[6] = '{3, 7'h40, 12'h001, 1'b0, 1'b0, 8'd3};

    bus.tdc_rdy = 1'b0;
    bus.rdata = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_rstr", bus.rstr, 1'b0);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_bc", bus.out_bc, 7'h00);
    check("rst_tdc", bus.out_tdc, 12'h000);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_err", bus.err_count, 8'd0);

    // Directed frame table, each checked at S+22 (R+9 for a timeout).
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rc = rstr_cnt;
      read_one(vecs[i].dly, vecs[i].bc, vecs[i].tdc, vecs[i].good);
      tick();
      check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_bc", i), bus.out_bc, vecs[i].bc);
        check($sformatf("vec%0d_tdc", i), bus.out_tdc, vecs[i].tdc);
      end
      check($sformatf("vec%0d_err", i), bus.err_count, vecs[i].exp_err);
      check($sformatf("vec%0d_rstr_pulses", i), rstr_cnt - rc, 1);
      tick();
    end
    check("table_overflow", bus.overflow, 1'b0);

    // Timeout with tdc_rdy held: error at R+9, re-request at R+10.
    rc = err_model;
    bus.tdc_rdy = 1'b1;
    wait_rstr();
    repeat (WAIT_MAX) tick();
    check("to_err_before", bus.err_count, 8'(rc));
    tick();
    check("to_err_r9", bus.err_count, 8'(rc + 1));
    check("to_rstr_r9", bus.rstr, 1'b0);
    err_model++;
    tick();
    check("to_rstr_r10", bus.rstr, 1'b1);
    bus.tdc_rdy = 1'b0;
    send_frame(4, 7'h2A, 12'h5A5, 1'b1);
    tick();
    check("to_next_valid", bus.out_valid, 1'b1);
    tick();

    // Backpressure: four buffered words, fifth request held off.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      read_one(2, 7'(i), 12'(i), 1'b1);
      tick();
    end
    rc = rstr_cnt;
    bus.tdc_rdy = 1'b1;
    repeat (20) tick();
    check("bp_no_rstr", rstr_cnt - rc, 0);
    check("bp_overflow", bus.overflow, 1'b1);
    check("bp_head_tdc", bus.out_tdc, 12'd1);
    bus.out_ready = 1'b1;
    wait_rstr();
    bus.tdc_rdy = 1'b0;
    send_frame(2, 7'd5, 12'd5, 1'b1);
    repeat (2) tick();
    check("bp_drained", exp_q.size(), 0);

    // Push and pop in the same cycle with one word held.
    bus.out_ready = 1'b0;
    read_one(3, 7'h11, 12'h111, 1'b1);
    tick();
    read_one(2, 7'h22, 12'h222, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    check("pp_valid", bus.out_valid, 1'b1);
    check("pp_bc", bus.out_bc, 7'h22);
    check("pp_tdc", bus.out_tdc, 12'h222);
    tick();
    check("pp_empty", bus.out_valid, 1'b0);

    // Reset in the middle of a frame with a word buffered.
    bus.out_ready = 1'b0;
    read_one(2, 7'h33, 12'h333, 1'b1);
    tick();
    w = {7'h6C, 12'h9E1};
    bus.tdc_rdy = 1'b1;
    wait_rstr();
    bus.tdc_rdy = 1'b0;
    repeat (2) tick();
    bus.rdata = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.rdata = w[WORD_W-1-k];
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rdata = 1'b0;
    check("mr_rstr", bus.rstr, 1'b0);
    check("mr_valid", bus.out_valid, 1'b0);
    check("mr_bc", bus.out_bc, 7'h00);
    check("mr_tdc", bus.out_tdc, 12'h000);
    check("mr_overflow", bus.overflow, 1'b0);
    check("mr_err", bus.err_count, 8'd0);
    exp_q.delete();
    err_model = 0;
    tick();
    bus.out_ready = 1'b1;
    read_one(6, 7'h6C, 12'h9E1, 1'b1);
    tick();
    check("mr_fresh_valid", bus.out_valid, 1'b1);
    check("mr_fresh_tdc", bus.out_tdc, 12'h9E1);
    check("mr_fresh_err", bus.err_count, 8'd0);
    tick();

    // Randomized frames with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      dly  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, WAIT_MAX));
      good = ($urandom_range(0, 6) != 0);
      read_one(dly, 7'($urandom), 12'($urandom), good);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (30) tick();
    check("rand_drained", exp_q.size(), 0);
    check("rand_err", bus.err_count, 8'(err_model));
    check("rand_valid", bus.out_valid, 1'b0);

    // Error counter saturation through repeated timeouts.
    bus.rdata = 1'b0;
    bus.tdc_rdy = 1'b1;
    repeat (10 * 270) tick();
    check("err_saturate", bus.err_count, 8'd255);
    bus.tdc_rdy = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tdcchan_readout.md
# tdcchan_readout

Readout controller at the host side of the TDC channel serial readout interface. It requests a measurement when the channel raises `tdc_rdy`, drives the `rstr` strobe, and deserializes the framed `rdata` bitstream into a bunch-crossing time and a fine TDC value. Checked words are buffered in a small FIFO and presented on a valid/ready stream toward the event builder. It runs in the 300 MHz domain next to the TDC channel.

## Interface
- `DATA_W`, 12: width of the fine TDC value (`tdc_out`).
- `BC_W`, 7: width of the bunch-crossing time (`bc_time`).
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `WAIT_MAX`, 8: cycles after `rstr` within which the start bit must arrive.
- `clk300`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tdc_rdy`  in  1  channel has a measurement pending; level, held until read.
- `rstr`  out  1  read strobe to channel; one-cycle pulse, registered.
- `rdata`  in  1  serial frame from channel, synchronous to `clk300`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head when high with `out_valid`.
- `out_bc`  out  BC_W  bunch-crossing time of head word.
- `out_tdc`  out  DATA_W  fine TDC value of head word.
- `overflow`  out  1  sticky: `tdc_rdy` was pending while FIFO full; cleared by reset only.
- `err_count`  out  8  saturating count of dropped frames (timeout or parity).

## Operation
- Frame on `rdata`, one bit per cycle: start bit (1), then `out_bc` MSB first, then `out_tdc` MSB first, then one even-parity bit. The ones count across the data and parity bits is even.
- FSM states: IDLE, REQ, WAIT_START, SHIFT, PARITY, PUSH.
- IDLE -> REQ when `tdc_rdy`=1 and the FIFO is not full. `rstr`=1 during REQ only.
- REQ -> WAIT_START unconditionally.
- WAIT_START samples `rdata` each cycle:
  - 1 -> SHIFT.
  - After `WAIT_MAX` zero samples -> IDLE, and `err_count` is incremented.
- SHIFT samples `BC_W+DATA_W` bits into the shift register, then -> PARITY.
- PARITY samples the parity bit:
  - Parity good -> PUSH.
  - Parity bad -> IDLE, `err_count` is incremented and the word is discarded.
- PUSH writes {bc, tdc} into the FIFO, then -> IDLE.
- The FIFO is first-word-fall-through:
  - `out_bc`/`out_tdc` show the head word whenever `out_valid`=1.
  - The head pops when `out_valid && out_ready`.
  - A push and a pop in the same cycle both take effect and leave the occupancy unchanged.
- When the FIFO is full, no `rstr` is issued. `tdc_rdy` stays pending and `overflow` is set in any cycle where `tdc_rdy`=1 and the FIFO is full in IDLE. No data is lost inside this block.
- A request is never issued while a frame is in progress. `tdc_rdy` changes outside IDLE are ignored.
- `err_count` saturates at 255.
- Reset values: `rstr`=0, `out_valid`=0, `out_bc`=0, `out_tdc`=0, `overflow`=0, `err_count`=0, FSM=IDLE, FIFO empty.
- Reset mid-frame aborts the frame, flushes the FIFO and does not count an error.

## Timing
- `rstr` is high in cycle R, which is the first cycle after IDLE sees the request condition.
- The start bit may be sampled at R+1 … R+`WAIT_MAX`. Call the sampling cycle S.
- Data bit k (k=0 … BC_W+DATA_W-1) is sampled at S+1+k. Parity is sampled at S+20 with the default widths.
- The FIFO write happens in PUSH at S+21. `out_valid` rises at S+22 when the FIFO was empty.
- The FSM is in IDLE at S+22. The earliest next `rstr` is S+23. Minimum frame-to-frame spacing is 23 cycles plus start latency.
- Timeout: with no start bit, the FSM returns to IDLE at R+`WAIT_MAX`+1 and `err_count` updates in the same cycle.
- `overflow` and `err_count` are registered and update one cycle after the condition.

## Test plan
- Single frame: `tdc_rdy`=1; channel model answers at R+2 with start, bc=0x55, tdc=0xABC, parity=1 -> exactly one `rstr` pulse; `out_valid`=1 at S+22 with `out_bc`=0x55, `out_tdc`=0xABC; `err_count`=0.
- Parity error: same frame with parity=0 -> no `out_valid`, `err_count`=1, FSM back in IDLE at S+21; a following good frame is received normally.
- Timeout: `tdc_rdy`=1, `rdata` held at 0 -> one `rstr`; `err_count`=1 at R+9; if `tdc_rdy` is still 1, a new `rstr` is issued at R+10.
- Backpressure: `out_ready`=0, send 5 good frames (tdc=1…5) -> 4 entries buffered, no fifth `rstr`, `overflow`=1; release `out_ready`=1 -> words 1…4 drain in order, the fifth frame is then requested and read.
- Simultaneous push/pop: FIFO holds 1 word and `out_ready`=1 during PUSH -> occupancy stays 1, order preserved.
- Reset mid-frame: assert `reset` at S+10 for one cycle -> all outputs at their reset values the next cycle, FIFO empty, `err_count`=0; a fresh frame afterwards is received correctly.
